// File: rtl/memory_controller_pkg.sv
// Shared definitions for the memory controller and its requesters:
// request direction, controller states, IO window and access widths.
package memory_controller_pkg;

    typedef enum logic {
        MC_READ  = 1'b0,
        MC_WRITE = 1'b1
    } mc_dir_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LSB_READ  = 3'd1,
        ST_LSB_WRITE = 3'd2,
        ST_IF_READ   = 3'd3,
        ST_DONE      = 3'd4
    } mc_state_e;

    // Addresses whose bits [17:16] match this base are memory-mapped IO.
    localparam logic [31:0] MC_IO_BASE = 32'h0003_0000;

    localparam logic [2:0] WIDTH_BYTE = 3'd1;
    localparam logic [2:0] WIDTH_HALF = 3'd2;
    localparam logic [2:0] WIDTH_WORD = 3'd4;

    // Any width code other than byte/half is serviced as a full word.
    function automatic logic [2:0] norm_width(input logic [2:0] w);
        case (w)
            WIDTH_BYTE: return WIDTH_BYTE;
            WIDTH_HALF: return WIDTH_HALF;
            default:    return WIDTH_WORD;
        endcase
    endfunction

endpackage

// File: rtl/memory_controller_byte_assembler.sv
// Byte counter plus little-endian assembly of RAM read bytes into a word.
// In cycle k (k >= 1) of a read, mem_din holds the byte addressed in cycle
// k-1, so a capture lands in byte lane cnt-1.
module mc_byte_assembler (
    input  logic        Sys_clk,
    input  logic        Sys_rst,
    input  logic        enable,
    input  logic        start,
    input  logic        advance,
    input  logic        capture,
    input  logic [7:0]  din,
    output logic [2:0]  cnt,
    output logic [31:0] word_next
);

    logic [31:0] word;
    logic [1:0]  slot;

    // Word as it will look after this cycle's capture.
    always_comb begin
        slot      = cnt[1:0] - 2'd1;
        word_next = word;
        if (capture) begin
            word_next[{slot, 3'b000} +: 8] = din;
        end
    end

    // Counter and assembled word; start clears both so unused lanes read 0.
    always_ff @(posedge Sys_clk or negedge Sys_rst) begin
        if (!Sys_rst) begin
            cnt  <= '0;
            word <= '0;
        end else if (enable) begin
            if (start) begin
                cnt  <= '0;
                word <= '0;
            end else begin
                if (advance) begin
                    cnt <= cnt + 3'd1;
                end
                word <= word_next;
            end
        end
    end

endmodule

// File: rtl/memory_controller.sv
// Memory controller: arbitrates LSB and instruction-fetch requests and
// serialises each into byte accesses on the single-port RAM/IO bus.
module memory_controller
    import memory_controller_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [31:0] IO_BASE    = MC_IO_BASE,
    parameter int unsigned IF_WIDTH   = 4
) (
    input  logic                  Sys_clk,
    input  logic                  Sys_rst,
    input  logic                  Sys_rdy,
    input  logic                  LSBMC_en,
    input  logic                  LSBMC_wr,
    input  logic [2:0]            LSBMC_data_width,
    input  logic [31:0]           LSBMC_data,
    input  logic [ADDR_WIDTH-1:0] LSBMC_addr,
    output logic                  MCLSB_r_en,
    output logic                  MCLSB_w_en,
    output logic [31:0]           MCLSB_data,
    input  logic                  IFMC_en,
    input  logic [ADDR_WIDTH-1:0] IFMC_addr,
    output logic                  MCIF_en,
    output logic [31:0]           MCIF_data,
    input  logic                  RoBMC_pre_judge,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    mc_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            width_q;
    logic [31:0]           data_q;

    logic        start, advance, capture;
    logic        wr_raw, io_stall;
    logic        done_rd, done_wr, done_if;
    logic [2:0]  cnt;
    logic [31:0] word_next;

    mc_byte_assembler u_asm (
        .Sys_clk   (Sys_clk),
        .Sys_rst   (Sys_rst),
        .enable    (Sys_rdy),
        .start     (start),
        .advance   (advance),
        .capture   (capture),
        .din       (mem_din),
        .cnt       (cnt),
        .word_next (word_next)
    );

    assign io_stall = (addr_q[17:16] == IO_BASE[17:16]) && io_buffer_full;

    // Next-state, bus drive and assembler control.
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        advance  = 1'b0;
        capture  = 1'b0;
        wr_raw   = 1'b0;
        mem_a    = '0;
        mem_dout = '0;
        case (state_q)
            ST_IDLE: begin
                if (LSBMC_en) begin
                    start   = 1'b1;
                    state_d = (mc_dir_e'(LSBMC_wr) == MC_WRITE) ? ST_LSB_WRITE : ST_LSB_READ;
                end else if (IFMC_en && RoBMC_pre_judge) begin
                    start   = 1'b1;
                    state_d = ST_IF_READ;
                end
            end
            ST_LSB_READ, ST_IF_READ: begin
                capture = (cnt != 3'd0);
                if (state_q == ST_IF_READ && !RoBMC_pre_judge) begin
                    state_d = ST_IDLE;
                end else if (cnt == width_q) begin
                    state_d = ST_DONE;
                end else begin
                    mem_a   = addr_q + ADDR_WIDTH'(cnt);
                    advance = 1'b1;
                end
            end
            ST_LSB_WRITE: begin
                mem_a    = addr_q + ADDR_WIDTH'(cnt);
                mem_dout = data_q[{cnt[1:0], 3'b000} +: 8];
                if (!io_stall) begin
                    wr_raw  = 1'b1;
                    advance = 1'b1;
                    if (cnt == width_q - 3'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        done_rd = (state_q == ST_LSB_READ)  && (state_d == ST_DONE);
        done_wr = (state_q == ST_LSB_WRITE) && (state_d == ST_DONE);
        done_if = (state_q == ST_IF_READ)   && (state_d == ST_DONE);
    end

    // A frozen controller must not commit a write.
    assign mem_wr = wr_raw & Sys_rdy;

    // State register.
    always_ff @(posedge Sys_clk or negedge Sys_rst) begin
        if (!Sys_rst) begin
            state_q <= ST_IDLE;
        end else if (Sys_rdy) begin
            state_q <= state_d;
        end
    end

    // Latch the winning request when leaving IDLE.
    always_ff @(posedge Sys_clk or negedge Sys_rst) begin
        if (!Sys_rst) begin
            addr_q  <= '0;
            width_q <= '0;
            data_q  <= '0;
        end else if (Sys_rdy && start) begin
            if (LSBMC_en) begin
                addr_q  <= LSBMC_addr;
                width_q <= norm_width(LSBMC_data_width);
                data_q  <= LSBMC_data;
            end else begin
                addr_q  <= IFMC_addr;
                width_q <= 3'(IF_WIDTH);
            end
        end
    end

    // Completion pulses and read data, registered so they are high in DONE.
    always_ff @(posedge Sys_clk or negedge Sys_rst) begin
        if (!Sys_rst) begin
            MCLSB_r_en <= 1'b0;
            MCLSB_w_en <= 1'b0;
            MCIF_en    <= 1'b0;
            MCLSB_data <= '0;
            MCIF_data  <= '0;
        end else if (Sys_rdy) begin
            MCLSB_r_en <= done_rd;
            MCLSB_w_en <= done_wr;
            MCIF_en    <= done_if;
            if (done_rd) begin
                MCLSB_data <= word_next;
            end
            if (done_if) begin
                MCIF_data <= word_next;
            end
        end
    end

endmodule

// File: tb/tb_memory_controller.sv
// Directed plus randomized bench for memory_controller with a RAM model
// and a transaction-level reference (expected words built from RAM bytes).
module tb_memory_controller;

    logic        Sys_clk = 1'b0;
    logic        Sys_rst, Sys_rdy;
    logic        LSBMC_en, LSBMC_wr;
    logic [2:0]  LSBMC_data_width;
    logic [31:0] LSBMC_data, LSBMC_addr;
    logic        MCLSB_r_en, MCLSB_w_en;
    logic [31:0] MCLSB_data;
    logic        IFMC_en;
    logic [31:0] IFMC_addr;
    logic        MCIF_en;
    logic [31:0] MCIF_data;
    logic        RoBMC_pre_judge;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;

    int total = 0;
    int bad   = 0;

    logic [7:0]  ram [logic [31:0]];
    logic [39:0] wlog [$];

    memory_controller #(.ADDR_WIDTH(32), .IF_WIDTH(4)) dut (
        .Sys_clk(Sys_clk), .Sys_rst(Sys_rst), .Sys_rdy(Sys_rdy),
        .LSBMC_en(LSBMC_en), .LSBMC_wr(LSBMC_wr), .LSBMC_data_width(LSBMC_data_width),
        .LSBMC_data(LSBMC_data), .LSBMC_addr(LSBMC_addr),
        .MCLSB_r_en(MCLSB_r_en), .MCLSB_w_en(MCLSB_w_en), .MCLSB_data(MCLSB_data),
        .IFMC_en(IFMC_en), .IFMC_addr(IFMC_addr), .MCIF_en(MCIF_en), .MCIF_data(MCIF_data),
        .RoBMC_pre_judge(RoBMC_pre_judge), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    always #5 Sys_clk = ~Sys_clk;

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // RAM: one-cycle read latency, writes committed and logged on the edge.
    always @(posedge Sys_clk) begin
        if (mem_wr) begin
            ram[mem_a] = mem_dout;
            wlog.push_back({mem_a, mem_dout});
        end
        mem_din <= ram_byte(mem_a);
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int width_bytes(input logic [2:0] w);
        return (w == 3'd1) ? 1 : (w == 3'd2) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
        logic [31:0] v = '0;
        for (int k = 0; k < n; k++) v = v | (32'(ram_byte(a + 32'(k))) << (8 * k));
        return v;
    endfunction

    task automatic wait_pulse(input int which, input int stall, input int frz_at, input int frz_len,
                              output int cyc, output logic [31:0] rdata);
        logic hit;
        cyc = 0;
        hit = 1'b0;
        rdata = '0;
        while (!hit && cyc < 100) begin
            @(negedge Sys_clk);
            cyc++;
            check32("pulse_overlap", 32'($countones({MCLSB_r_en, MCLSB_w_en, MCIF_en}) <= 1), 32'd1);
            if (stall > 0 && cyc <= stall) check32("io_stall_nowr", 32'(mem_wr), 32'd0);
            if (!Sys_rdy) check32("freeze_nowr", 32'(mem_wr), 32'd0);
            hit   = (which == 0) ? MCLSB_r_en : (which == 1) ? MCLSB_w_en : MCIF_en;
            rdata = (which == 2) ? MCIF_data : MCLSB_data;
            if (stall > 0 && cyc == stall + 1) io_buffer_full = 1'b0;
            if (frz_len > 0 && cyc == frz_at) Sys_rdy = 1'b0;
            if (frz_len > 0 && cyc == frz_at + frz_len) Sys_rdy = 1'b1;
        end
        if (!hit) check32("pulse_timeout", 32'(hit), 32'd1);
    endtask

    task automatic lsb_txn(input logic wr, input logic [2:0] w, input logic [31:0] d, input logic [31:0] a,
                           input int stall, input int frz_at, input int frz_len, output logic [31:0] got);
        int n, cyc;
        logic [31:0] exp;
        n   = width_bytes(w);
        exp = model_read(a, n);
        wlog.delete();
        LSBMC_en = 1'b1; LSBMC_wr = wr; LSBMC_data_width = w; LSBMC_data = d; LSBMC_addr = a;
        if (stall > 0) io_buffer_full = 1'b1;
        wait_pulse(wr ? 1 : 0, stall, frz_at, frz_len, cyc, got);
        LSBMC_en = 1'b0;
        if (wr) begin
            check32("st_latency", 32'(cyc), 32'(n + 1 + stall + frz_len));
            check32("st_count", 32'(wlog.size()), 32'(n));
            for (int k = 0; k < n && k < wlog.size(); k++) begin
                check32("st_addr", wlog[k][39:8], a + 32'(k));
                check32("st_byte", 32'(wlog[k][7:0]), 32'(d[8*k +: 8]));
            end
        end else begin
            check32("ld_latency", 32'(cyc), 32'(n + 2 + frz_len));
            check32("ld_data", got, exp);
        end
        @(negedge Sys_clk);
        check32("pulse_single", 32'({MCLSB_r_en, MCLSB_w_en}), 32'd0);
        check32("no_extra_wr", 32'(wlog.size()), wr ? 32'(n) : 32'd0);
    endtask

    task automatic if_txn(input logic [31:0] a, output logic [31:0] got);
        int cyc;
        logic [31:0] exp;
        exp = model_read(a, 4);
        IFMC_en = 1'b1; IFMC_addr = a;
        wait_pulse(2, 0, 0, 0, cyc, got);
        IFMC_en = 1'b0;
        check32("if_latency", 32'(cyc), 32'd6);
        check32("if_data", got, exp);
        @(negedge Sys_clk);
        check32("if_pulse_single", 32'(MCIF_en), 32'd0);
    endtask

    initial begin
        logic [31:0] got, exp_a, exp_b;
        int cyc;
        logic [2:0] wtab [5];
        wtab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};

        Sys_rst = 1'b0; Sys_rdy = 1'b1; LSBMC_en = 1'b0; LSBMC_wr = 1'b0;
        LSBMC_data_width = 3'd0; LSBMC_data = '0; LSBMC_addr = '0;
        IFMC_en = 1'b0; IFMC_addr = '0; RoBMC_pre_judge = 1'b1; io_buffer_full = 1'b0;
        ram[32'h1000] = 8'h11; ram[32'h1001] = 8'h22; ram[32'h1002] = 8'h33; ram[32'h1003] = 8'h44;
        #2;
        check32("rst_outputs", {MCLSB_r_en, MCLSB_w_en, MCIF_en, mem_wr, mem_dout, 20'd0}, 32'd0);
        check32("rst_mem_a", mem_a, 32'd0);
        check32("rst_lsb_data", MCLSB_data, 32'd0);
        @(negedge Sys_clk); @(negedge Sys_clk);
        Sys_rst = 1'b1;
        @(negedge Sys_clk);

        // lw at 0x1000
        lsb_txn(1'b0, 3'd4, 32'h0, 32'h1000, 0, 0, 0, got);
        check32("lw_1000", got, 32'h4433_2211);

        // sb: only the low byte goes out
        lsb_txn(1'b1, 3'd1, 32'hAABB_CCDD, 32'h2003, 0, 0, 0, got);
        lsb_txn(1'b0, 3'd1, 32'h0, 32'h2003, 0, 0, 0, got);
        check32("sb_readback", got, 32'h0000_00DD);

        // lh and fetch raised together: LSB first, fetch after DONE
        exp_a = model_read(32'h1002, 2);
        exp_b = model_read(32'h0100, 4);
        LSBMC_en = 1'b1; LSBMC_wr = 1'b0; LSBMC_data_width = 3'd2; LSBMC_addr = 32'h1002;
        IFMC_en = 1'b1; IFMC_addr = 32'h0100;
        wait_pulse(0, 0, 0, 0, cyc, got);
        LSBMC_en = 1'b0;
        check32("arb_lsb_latency", 32'(cyc), 32'd4);
        check32("arb_lsb_data", got, exp_a);
        wait_pulse(2, 0, 0, 0, cyc, got);
        IFMC_en = 1'b0;
        check32("arb_if_latency", 32'(cyc), 32'd7);
        check32("arb_if_data", got, exp_b);
        @(negedge Sys_clk);

        // flush in the middle of a fetch
        IFMC_en = 1'b1; IFMC_addr = 32'h5000;
        for (int i = 1; i <= 3; i++) begin
            @(negedge Sys_clk);
            check32("flush_no_pulse", 32'(MCIF_en), 32'd0);
        end
        RoBMC_pre_judge = 1'b0; IFMC_en = 1'b0;
        @(negedge Sys_clk);
        check32("flush_idle_a", mem_a, 32'd0);
        check32("flush_no_pulse2", 32'(MCIF_en), 32'd0);
        RoBMC_pre_judge = 1'b1;
        @(negedge Sys_clk);
        check32("flush_no_pulse3", 32'(MCIF_en), 32'd0);
        if_txn(32'h0, got);

        // fetch not accepted in IDLE while flush is asserted
        IFMC_en = 1'b1; IFMC_addr = 32'h6000; RoBMC_pre_judge = 1'b0;
        @(negedge Sys_clk); @(negedge Sys_clk);
        check32("flush_idle_block", mem_a, 32'd0);
        RoBMC_pre_judge = 1'b1;
        if_txn(32'h6000, got);

        // IO store stalled by a full buffer for three cycles
        lsb_txn(1'b1, 3'd4, 32'hCAFE_F00D, 32'h0003_0000, 3, 0, 0, got);

        // freeze during a store
        lsb_txn(1'b1, 3'd4, 32'h1357_9BDF, 32'h7000, 0, 2, 3, got);
        lsb_txn(1'b0, 3'd4, 32'h0, 32'h7000, 0, 0, 0, got);
        check32("frz_readback", got, 32'h1357_9BDF);

        // wrap-around and width codes 0/3
        lsb_txn(1'b0, 3'd4, 32'h0, 32'hFFFF_FFFE, 0, 0, 0, got);
        lsb_txn(1'b1, 3'd2, 32'h0000_BEEF, 32'hFFFF_FFFF, 0, 0, 0, got);
        lsb_txn(1'b0, 3'd3, 32'h0, 32'h1000, 0, 0, 0, got);
        check32("w3_as_word", got, 32'h4433_2211);
        lsb_txn(1'b0, 3'd0, 32'h0, 32'h1000, 0, 0, 0, got);
        check32("w0_as_word", got, 32'h4433_2211);

        // randomized traffic
        for (int i = 0; i < 24; i++) begin
            int op;
            logic [31:0] ra, rd;
            op = $urandom_range(0, 2);
            ra = 32'($urandom_range(0, 32'h0000_FFFF));
            rd = $urandom;
            if (op == 2) if_txn(ra, got);
            else lsb_txn(op == 1, wtab[$urandom_range(0, 4)], rd, ra, 0, 0, 0, got);
        end

        // asynchronous reset during byte 1 of a store
        wlog.delete();
        LSBMC_en = 1'b1; LSBMC_wr = 1'b1; LSBMC_data_width = 3'd4;
        LSBMC_data = 32'h1122_3344; LSBMC_addr = 32'h4000;
        @(negedge Sys_clk); @(negedge Sys_clk);
        check32("rst_mid_a", mem_a, 32'h4001);
        check32("rst_mid_wr", 32'(mem_wr), 32'd1);
        Sys_rst = 1'b0;
        #1;
        check32("rst_async_out", {MCLSB_r_en, MCLSB_w_en, MCIF_en, mem_wr, mem_dout, 20'd0}, 32'd0);
        check32("rst_async_a", mem_a, 32'd0);
        check32("rst_async_ldata", MCLSB_data, 32'd0);
        check32("rst_async_ifdata", MCIF_data, 32'd0);
        check32("rst_wr_count", 32'(wlog.size()), 32'd1);
        LSBMC_en = 1'b0;
        @(negedge Sys_clk);
        Sys_rst = 1'b1;
        @(negedge Sys_clk);
        lsb_txn(1'b0, 3'd1, 32'h0, 32'h4000, 0, 0, 0, got);
        check32("rst_after_byte0", got, 32'h0000_0044);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
